// File: rtl/fifo_buffer_if.sv
// Push/pop handshake bundle for fifo_buffer: the producer drives it through the master modport,
// and the FIFO drives the data and status lines through the slave modport.
interface fifo_buffer_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              push;
    logic              pop;
    logic              clr_err;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic [CW-1:0]     count;
    logic              overflow;
    logic              underflow;

    modport master (
        output push, pop, clr_err, wdata,
        input  rdata, full, empty, almost_full, count, overflow, underflow
    );

    modport slave (
        input  push, pop, clr_err, wdata,
        output rdata, full, empty, almost_full, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_buffer.sv
// Single-clock FIFO with registered read data, almost-full level and sticky overflow/underflow flags.
// Define FIFO_BUFFER_ASSERT_EN to compile in immediate assertions on illegal push/pop and occupancy.
module fifo_buffer #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AFULL_LVL = 12
) (
    input  logic          clk,
    input  logic          rst,
    fifo_buffer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              afull_q, afull_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              push_ok, pop_ok;

    always_comb begin
        // A push into a full FIFO still succeeds when a pop frees the head slot in the same edge.
        push_ok  = bus.push && (!full_q || bus.pop);
        pop_ok   = bus.pop && !empty_q;

        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
        rdata_d  = pop_ok ? mem[rd_ptr_q] : rdata_q;

        full_d   = (count_d == CW'(DEPTH));
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= CW'(AFULL_LVL));

        ovf_d    = (ovf_q && !bus.clr_err) || (bus.push && !push_ok);
        unf_d    = (unf_q && !bus.clr_err) || (bus.pop && !pop_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rdata_q  <= rdata_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage is deliberately left out of reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= bus.wdata;
        end
    end

    assign bus.rdata       = rdata_q;
    assign bus.full        = full_q;
    assign bus.empty       = empty_q;
    assign bus.almost_full = afull_q;
    assign bus.count       = count_q;
    assign bus.overflow    = ovf_q;
    assign bus.underflow   = unf_q;

`ifdef FIFO_BUFFER_ASSERT_EN
    logic [AW-1:0] ptr_diff;
    assign ptr_diff = wr_ptr_q - rd_ptr_q;

    always @(posedge clk) begin
        if (!rst) begin
            assert (!(bus.push && full_q && !bus.pop))
                else $error("[FAIL] push when fifo full !");
            assert (!(bus.pop && empty_q))
                else $error("[FAIL] pop when fifo empty !");
            // Equal pointers are ambiguous; the full flag decides between 0 and DEPTH.
            assert (full_q ? (count_q == CW'(DEPTH) && ptr_diff == '0)
                           : (count_q == {1'b0, ptr_diff}))
                else $error("[FAIL] count does not match pointer difference !");
        end
    end
`endif
endmodule

// File: tb/tb_fifo_buffer.sv
// Scoreboard bench for fifo_buffer: directed scenarios with hand-computed values plus a queue-model random run.
module tb_fifo_buffer;
    localparam int DATA_W    = 8;
    localparam int DEPTH     = 16;
    localparam int AFULL_LVL = 12;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fifo_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus();

    fifo_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_LVL(AFULL_LVL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         seq;
        logic [7:0] rdata;
        int         count;
        bit         full;
        bit         empty;
        bit         afull;
        bit         ovf;
        bit         unf;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   seq      = 0;

    int         mq[$];
    logic [7:0] m_rdata = 8'h00;
    bit         m_ovf   = 1'b0;
    bit         m_unf   = 1'b0;

    task automatic chk(input string name, input int s, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s step=%0d actual=0x%0h required=0x%0h", name, s, act, req);
        end
    endtask

    // Drives one cycle of stimulus, advances the queue model and queues the post-edge expectation.
    task automatic step(input bit p, input bit q, input logic [7:0] d, input bit c);
        exp_t e;
        bit   pok;
        bit   wok;
        @(negedge clk);
        bus.push    = p;
        bus.pop     = q;
        bus.wdata   = d;
        bus.clr_err = c;
        pok = q && (mq.size() > 0);
        wok = p && ((mq.size() < DEPTH) || q);
        if (pok) m_rdata = 8'(mq.pop_front());
        if (wok) mq.push_back(int'(d));
        m_ovf = (m_ovf && !c) || (p && !wok);
        m_unf = (m_unf && !c) || (q && !pok);
        seq++;
        e.seq   = seq;
        e.rdata = m_rdata;
        e.count = mq.size();
        e.full  = (mq.size() == DEPTH);
        e.empty = (mq.size() == 0);
        e.afull = (mq.size() >= AFULL_LVL);
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.wdata   = '0;
        bus.clr_err = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"},     seq, int'(bus.count),       0);
        chk({tag, "_empty"},     seq, int'(bus.empty),       1);
        chk({tag, "_full"},      seq, int'(bus.full),        0);
        chk({tag, "_afull"},     seq, int'(bus.almost_full), 0);
        chk({tag, "_rdata"},     seq, int'(bus.rdata),       0);
        chk({tag, "_overflow"},  seq, int'(bus.overflow),    0);
        chk({tag, "_underflow"}, seq, int'(bus.underflow),   0);
    endtask

    // Monitor: after every edge that had stimulus queued, compare the DUT against that expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_rdata",     e.seq, int'(bus.rdata),       int'(e.rdata));
                chk("sb_count",     e.seq, int'(bus.count),       e.count);
                chk("sb_full",      e.seq, int'(bus.full),        int'(e.full));
                chk("sb_empty",     e.seq, int'(bus.empty),       int'(e.empty));
                chk("sb_afull",     e.seq, int'(bus.almost_full), int'(e.afull));
                chk("sb_overflow",  e.seq, int'(bus.overflow),    int'(e.ovf));
                chk("sb_underflow", e.seq, int'(bus.underflow),   int'(e.unf));
            end
        end
    end

    initial begin
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.wdata   = '0;
        bus.clr_err = 1'b0;

        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_state("por");
        rst = 1'b0;

        // Reset mid-clock with 5 words held and a non-zero rdata.
        for (int i = 1; i <= 6; i++) step(1'b1, 1'b0, 8'(i), 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("pre_reset_rdata", seq, int'(bus.rdata), 1);
        chk("pre_reset_count", seq, int'(bus.count), 5);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk_reset_state("midrst");
        mq.delete();
        m_rdata = 8'h00;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Fill 0x00..0x0F.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 8'(i), 1'b0);
            if (i == 0)  chk("first_push_count", seq, int'(bus.count), 1);
            if (i == 10) chk("fill11_afull", seq, int'(bus.almost_full), 0);
            if (i == 11) chk("fill12_afull", seq, int'(bus.almost_full), 1);
            if (i == 14) chk("fill15_full",  seq, int'(bus.full), 0);
        end
        chk("fill16_full",  seq, int'(bus.full),  1);
        chk("fill16_count", seq, int'(bus.count), 16);

        // Overflow on a full FIFO, then clear.
        step(1'b1, 1'b0, 8'hAA, 1'b0);
        chk("ovf_count", seq, int'(bus.count),    16);
        chk("ovf_flag",  seq, int'(bus.overflow), 1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("ovf_cleared", seq, int'(bus.overflow), 0);

        // Drain: 0xAA must not have been stored.
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 8'h00, 1'b0);
            chk("drain_rdata", seq, int'(bus.rdata), i);
        end
        chk("drain_empty", seq, int'(bus.empty), 1);
        chk("drain_count", seq, int'(bus.count), 0);

        // Push+pop on an empty FIFO.
        step(1'b1, 1'b1, 8'h55, 1'b0);
        chk("emptypp_count", seq, int'(bus.count),     1);
        chk("emptypp_unf",   seq, int'(bus.underflow), 1);
        chk("emptypp_rdata", seq, int'(bus.rdata),     8'h0F);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("emptypp_pop_rdata", seq, int'(bus.rdata), 8'h55);
        chk("emptypp_pop_empty", seq, int'(bus.empty), 1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("unf_cleared", seq, int'(bus.underflow), 0);

        // Push+pop on a full FIFO, then drain across the pointer wrap.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
        step(1'b1, 1'b1, 8'h99, 1'b0);
        chk("fullpp_rdata", seq, int'(bus.rdata),    8'h10);
        chk("fullpp_count", seq, int'(bus.count),    16);
        chk("fullpp_ovf",   seq, int'(bus.overflow), 0);
        for (int i = 1; i < 16; i++) begin
            step(1'b0, 1'b1, 8'h00, 1'b0);
            chk("fullpp_drain", seq, int'(bus.rdata), 8'h10 + i);
        end
        step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("wrap_last_rdata", seq, int'(bus.rdata), 8'h99);
        chk("wrap_empty",      seq, int'(bus.empty), 1);

        // Random traffic against the queue model.
        for (int i = 0; i < 1000; i++) begin
            step(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 45),
                 8'($urandom_range(0, 255)), ($urandom_range(0, 15) == 0));
        end

        @(negedge clk);
        chk("scoreboard_drained", seq, exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_buffer.md
# fifo_buffer

Synchronous single-clock FIFO that owns the storage and occupancy flags for the push/pop handshake. It sits directly downstream of the producer driving `push`/`pop` and is the source of the `full`/`empty` flags that the design-side push/pop checkers sample on every `clk` edge. It also provides registered read data, an almost-full level, and sticky overflow/underflow error flags.

## Interface
- `DATA_W`, 8: width of stored words.
- `DEPTH`, 16: number of entries; power of two, ≥ 2.
- `AFULL_LVL`, 12: `almost_full` asserts when `count ≥ AFULL_LVL`; legal range 1..DEPTH.

- `clk`  in  1  sole clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `push`  in  1  write request, sampled at posedge.
- `wdata`  in  DATA_W  write data, captured with an accepted push.
- `pop`  in  1  read request, sampled at posedge.
- `rdata`  out  DATA_W  registered head word from the last accepted pop.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `almost_full`  out  1  `count ≥ AFULL_LVL`.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky; a push was rejected.
- `underflow`  out  1  sticky; a pop was rejected.
- `clr_err`  in  1  synchronous clear of `overflow`/`underflow`.

## Operation
- Storage is `DEPTH × DATA_W`. Write and read pointers are `$clog2(DEPTH)` bits and wrap naturally from DEPTH-1 to 0.
- Accept rules, evaluated on pre-edge state:
  - push_ok = push && (!full || pop).
  - pop_ok = pop && !empty.
- push_ok: `mem[wr_ptr] <= wdata`, then wr_ptr+1.
- pop_ok: `rdata <= mem[rd_ptr]`, then rd_ptr+1. Without pop_ok, `rdata` holds its value.
- `count` next = count + push_ok − pop_ok. The flags `full`, `empty` and `almost_full` are registered and updated in the same edge as `count`.
- Simultaneous push+pop:
  - Full FIFO: both accepted, count unchanged, no overflow.
  - Empty FIFO: push accepted, pop rejected, count becomes 1, underflow sets.
  - Otherwise: both accepted, count unchanged.
- Error flags:
  - Rejected push sets `overflow`; rejected pop sets `underflow`.
  - `clr_err` clears both flags. If a new error occurs in the same cycle as `clr_err`, the set takes priority.
  - A rejected operation never modifies pointers, memory or `rdata`.
- No state machine beyond the pointers and count.

## Timing
- Reset values (asynchronous, immediate on `rst` rise):
  - wr_ptr = rd_ptr = 0, count = 0.
  - empty = 1, full = 0, almost_full = 0.
  - overflow = underflow = 0, rdata = 0.
  - Memory contents are not reset.
- Reset mid-operation: all in-flight contents are discarded. First push after `rst` falls is accepted at the first posedge.
- Write-to-read: a word pushed at edge N can be popped at edge N+1 or later. It appears on `rdata` just after that pop edge, so the read latency is 1 cycle from the pop request.
- All outputs change only on posedge `clk` or on `rst`. There is no combinational path from inputs to outputs.

## Configuration
- `FIFO_BUFFER_ASSERT_EN`: when defined, the block compiles in immediate assertions checked at posedge when `rst` is low:
  - `push && full && !pop` fails with "[FAIL] push when fifo full !".
  - `pop && empty` fails with "[FAIL] pop when fifo empty !".
  - `count` must equal the pointer difference modulo DEPTH, with full resolved by the flags.
  - Passing checks print nothing.
- Without the macro, there are no assertions and no messages. The sticky flags still record errors, and RTL behaviour is identical.

## Test plan
- Reset: assert `rst` mid-clock with count=5 → immediately count=0, empty=1, full=0, rdata=0, overflow=underflow=0.
- Fill/drain: push 0x00..0x0F (16 words) → after 12th push almost_full=1, after 16th full=1. Then pop 16 → rdata sequence 0x00..0x0F, final empty=1, count=0.
- Overflow: FIFO full, push=1, pop=0, wdata=0xAA → count stays 16, overflow=1, data unchanged. Pulse clr_err → overflow=0.
- Underflow/simultaneous on empty: push=1, pop=1, wdata=0x55 → count=1, underflow=1, rdata unchanged. Next pop → rdata=0x55, empty=1.
- Full push+pop: FIFO full of 0x10..0x1F, push 0x99 with pop → rdata=0x10, count=16, overflow=0. Drain → last word read is 0x99, confirming pointer wrap.
- Random push/pop 1000 cycles against a queue model → rdata, count and flags match every cycle. With `FIFO_BUFFER_ASSERT_EN` defined, fail messages appear only for illegal cycles.
